my_top_level: RTL and testbench



---
 rtl/my_top_level_pkg.sv | 10 +
 rtl/my_top_level_adder_comb.sv | 14 +
 rtl/my_top_level.sv | 49 ++++
 tb/tb_my_top_level.sv | 137 +++++++++++++
 4 files changed

// File: rtl/my_top_level_pkg.sv
// Shared types and constants for the registered adder slice.
package my_top_level_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef logic [WIDTH_DEFAULT-1:0] operand_t;

  localparam operand_t RESULT_RST = '0;

endpackage

// File: rtl/my_top_level_adder_comb.sv
// Purely combinational unsigned adder exposing both the WIDTH-bit sum and the carry-out.
module adder_comb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c
);

  // Widen both operands before adding so the carry is captured explicitly.
  assign {carry_c, sum_c} = (WIDTH+1)'(a) + (WIDTH+1)'(b);

endmodule

// File: rtl/my_top_level.sv
// Registered modulo-2^WIDTH adder: samples io_A/io_B every edge, one-cycle latency,
// synchronous active-low reset clears the result.
module my_top_level
  import my_top_level_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  output logic [WIDTH-1:0] io_X
);

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic [WIDTH-1:0] result_q;

  adder_comb #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a       (io_A),
    .b       (io_B),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  // Result register; reset overrides the sum on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= WIDTH'(RESULT_RST);
    end else begin
      result_q <= sum_c;
    end
  end

  assign io_X = result_q;

  // Carry is deliberately dropped from the datapath; it only backs the width check below.
  a_full_sum : assert property (@(posedge clk)
    {carry_c, sum_c} == ((WIDTH+1)'(io_A) + (WIDTH+1)'(io_B)));

  a_sum_after_run : assert property (@(posedge clk)
    $past(reset) |-> (io_X == WIDTH'($past(io_A) + $past(io_B))));

  a_zero_after_rst : assert property (@(posedge clk)
    !$past(reset) |-> (io_X == '0));

endmodule

// File: tb/tb_my_top_level.sv
// Self-checking bench for my_top_level: vector table, directed multi-cycle sequences,
// and a randomized run against an integer-arithmetic reference model.
module tb_my_top_level;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] io_A;
  logic [W-1:0] io_B;
  logic [W-1:0] io_X;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rst_n;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[14];

  my_top_level #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_A  (io_A),
    .io_B  (io_B),
    .io_X  (io_X)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operand pair away from the edge, then let the edge land and settle.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    @(negedge clk);
    io_A  = a;
    io_B  = b;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic r);
    int s;
    s = (int'(a) + int'(b)) % 256;
    return r ? W'(s) : W'(0);
  endfunction

  initial begin
    logic [1599:0] pat;
    logic [15:0]   data;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          rr;
    logic [W-1:0]  held;

    checks = 0;
    errors = 0;
    io_A   = 8'h12;
    io_B   = 8'h34;
    reset  = 1'b0;

    tbl[0]  = '{8'h05, 8'h03, 1'b1, 8'h08};
    tbl[1]  = '{8'h00, 8'h00, 1'b1, 8'h00};
    tbl[2]  = '{8'hFF, 8'h01, 1'b1, 8'h00};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFE};
    tbl[4]  = '{8'h80, 8'h80, 1'b1, 8'h00};
    tbl[5]  = '{8'h7F, 8'h01, 1'b1, 8'h80};
    tbl[6]  = '{8'hA5, 8'h5A, 1'b1, 8'hFF};
    tbl[7]  = '{8'hA5, 8'h5A, 1'b1, 8'hFF};
    tbl[8]  = '{8'hC3, 8'h3C, 1'b0, 8'h00};
    tbl[9]  = '{8'h10, 8'h20, 1'b1, 8'h30};
    tbl[10] = '{8'hFE, 8'h01, 1'b1, 8'hFF};
    tbl[11] = '{8'h01, 8'hFE, 1'b1, 8'hFF};
    tbl[12] = '{8'hFF, 8'hFF, 1'b0, 8'h00};
    tbl[13] = '{8'h00, 8'hFF, 1'b1, 8'hFF};

    // Reset hold for 10 cycles with non-zero operands present.
    for (int i = 0; i < 10; i++) begin
      step(8'h12, 8'h34, 1'b0);
      check("reset_hold", io_X, 8'h00);
    end
    step(8'h12, 8'h34, 1'b1);
    check("reset_release", io_X, 8'h46);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].rst_n);
      check($sformatf("vec%0d", i), io_X, tbl[i].exp);
    end

    // Inputs changing between edges must not reach the output.
    step(8'h21, 8'h11, 1'b1);
    held = io_X;
    check("mid_cycle_pre", held, 8'h32);
    io_A = 8'hEE;
    io_B = 8'h77;
    #2;
    check("mid_cycle_hold", io_X, 8'h32);

    // Back-to-back stream of incrementing bytes, with one reset pulse at k=50.
    for (int i = 0; i < 200; i++) pat[8*i +: 8] = 8'(i);
    for (int k = 0; k < 100; k++) begin
      data = pat[15:0];
      pat  = pat >> 16;
      rr   = (k != 50);
      step(data[7:0], data[15:8], rr);
      check($sformatf("stream_k%0d", k), io_X, rr ? 8'((4 * k + 1) % 256) : 8'h00);
    end

    // Randomized run with occasional single-cycle reset pulses.
    for (int n = 0; n < 10000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rr = ($urandom_range(0, 49) != 0);
      step(ra, rb, rr);
      check("random", io_X, model(ra, rb, rr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
